replay_protection_rx: RTL and testbench
=======================================

Name: replay_protection_rx

Overview:
Receive-side counterpart of the replay-protection transmitter. It consumes the serial byte stream of frames, each frame being PAYLOAD_LEN payload bytes followed by one 8-bit replay counter byte. The block buffers the payload and checks the counter against the last accepted counter. Frames with a fresh counter are released downstream byte by byte; replayed or stale frames are dropped and flagged. It sits between the UART/serial byte receiver and the application consumer.

Parameters:
PAYLOAD_LEN, 8, payload bytes per frame; the counter byte follows as byte PAYLOAD_LEN. Range 1..15.
WINDOW, 16, maximum accepted forward jump of the counter (modulo 256). Range 1..255.
ERR_CNT_W, 8, width of the saturating rejected-frame counter.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
data_in  in  8  received byte
data_valid  in  1  single-cycle strobe; data_in is valid this cycle
in_ready  out  1  high when a byte can be captured
data_out  out  8  released payload byte
data_out_valid  out  1  data_out is valid this cycle (no backpressure)
frame_last  out  1  high with the last payload byte of an accepted frame
replay_error  out  1  one-cycle pulse when a frame is rejected
overrun  out  1  one-cycle pulse when a byte arrives while in_ready=0
err_count  out  ERR_CNT_W  saturating count of rejected frames
last_count  out  8  last accepted counter value

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to COLLECT; byte index is 0.
  - in_ready=1. All other outputs are 0: data_out, data_out_valid, frame_last, replay_error, overrun, err_count, last_count.
  - last_count resets to 0, so the first frame after reset (counter 1) is accepted.
- States: COLLECT, CHECK, DRAIN.
- COLLECT:
  - in_ready=1.
  - On data_valid, store data_in at buffer[idx] and increment idx.
  - When idx==PAYLOAD_LEN, the byte is the counter: store it in rx_cnt, clear idx, go to CHECK.
  - in_ready drops in the cycle after the counter byte is captured.
- CHECK (one cycle):
  - diff = (rx_cnt - last_count) mod 256, computed in 8 bits.
  - Accept if 1 <= diff <= WINDOW.
  - Accept: last_count <= rx_cnt; go to DRAIN.
  - Reject (covers diff==0 replay, backward counters, and jumps larger than WINDOW): replay_error pulses for one cycle; err_count increments, saturating at all-ones; last_count is unchanged; go to COLLECT.
- DRAIN:
  - Output buffer[0..PAYLOAD_LEN-1], one byte per consecutive cycle, with data_out_valid=1.
  - frame_last=1 on the final byte.
  - Return to COLLECT in the following cycle.
  - data_out holds its last value while data_out_valid=0.
- Latency:
  - First payload byte appears 2 cycles after the counter byte is captured: capture edge, then CHECK, then DRAIN.
  - replay_error appears with the same timing as that first byte.
- in_ready is 0 in CHECK and DRAIN.
  - A data_valid in those states drops the byte and pulses overrun in the next cycle.
  - The buffer and idx are not affected.
- Wrap-around: the counter comparison is modulo 256. Example: last_count=250, rx_cnt=4 gives diff=10, which is accepted.
- Reset mid-frame or mid-drain: all partial state is discarded. The next byte after release is treated as byte 0 of a new frame.
- Outputs data_out_valid, frame_last, replay_error and overrun are registered and are never combinational from inputs.

Decomposition:
- Shared package replay_pkg holds:
  - state encodings: COLLECT, CHECK, DRAIN;
  - default frame length 8 and counter width 8, shared with the transmitter;
  - a function computing the modulo-256 difference.
- One natural sub-module: replay_frame_buffer. It is a PAYLOAD_LEN x 8 register file with a write port (we, waddr, wdata) and a registered read port (raddr, rdata).
- The FSM, counter check and error counter stay in the top level.

Test Plan:
- Reset, then send payload 0x10..0x17 followed by counter 0x01 -> data_out 0x10..0x17 on 8 consecutive cycles, 2 cycles after the counter byte; frame_last on 0x17; last_count=0x01.
- Resend the same frame with counter 0x01 -> no data_out_valid; replay_error pulses once; err_count=1; last_count remains 0x01.
- From last_count=0x01, send counter 0x11 (diff 16) -> accepted. Then send counter 0x22 (diff 17) -> rejected, err_count increments.
- Preload last_count=0xFA via accepted frames, then send counter 0x04 -> accepted across the wrap; last_count=0x04.
- Assert data_valid during DRAIN -> overrun pulses; drained bytes are unchanged; the next frame is captured correctly.
- Assert reset_n low during DRAIN at byte 3 -> all outputs are 0 immediately; after release, a fresh frame with counter 0x01 is accepted.

Source files
------------

// File: rtl/replay_pkg.sv
// Shared definitions for the replay-protection transmitter/receiver pair:
// FSM encodings, default frame geometry and the modulo-256 counter distance.
package replay_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int DEF_PAYLOAD_LEN = 8;
  localparam int CNT_W           = 8;
  // Byte index width; covers payload lengths up to 15 plus the counter slot.
  localparam int IDX_W           = 4;

  // Forward distance from 'last' to 'rx', wrapping modulo 2**CNT_W.
  function automatic logic [CNT_W-1:0] mod_diff(input logic [CNT_W-1:0] rx,
                                                 input logic [CNT_W-1:0] last);
    return rx - last;
  endfunction

endpackage

// File: rtl/replay_frame_buffer.sv
// Payload register file: one synchronous write port and a registered read
// port whose output holds its value unless a read is requested.
module replay_frame_buffer
  import replay_pkg::*;
#(
  parameter int AW = IDX_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // Storage array: capture incoming payload bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end else begin
      mem <= mem;
    end
  end

  // Registered read: output only changes on a read request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= 8'h00;
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/replay_protection_rx.sv
// Receive-side replay protection: buffers one frame of payload bytes, checks
// the trailing counter byte against the last accepted counter (modulo 256,
// forward window), then releases accepted payloads or flags rejected ones.
module replay_protection_rx
  import replay_pkg::*;
#(
  parameter int PAYLOAD_LEN = DEF_PAYLOAD_LEN,
  parameter int WINDOW      = 16,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           data_in,
  input  logic                 data_valid,
  output logic                 in_ready,
  output logic [7:0]           data_out,
  output logic                 data_out_valid,
  output logic                 frame_last,
  output logic                 replay_error,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           last_count
);

  localparam logic [IDX_W-1:0] PLEN     = IDX_W'(PAYLOAD_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [7:0]       WIN8     = 8'(WINDOW);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] drain_idx;
  logic [IDX_W-1:0] drain_idx_next;
  logic [7:0]       rx_cnt;
  logic [7:0]       diff;
  logic             accept;
  logic             cnt_capture;
  logic             buf_we;
  logic             buf_re;
  logic [IDX_W-1:0] buf_raddr;
  logic             valid_next;
  logic             last_next;
  logic             err_next;

  replay_frame_buffer #(
    .AW (IDX_W)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (buf_we),
    .waddr   (idx),
    .wdata   (data_in),
    .re      (buf_re),
    .raddr   (buf_raddr),
    .rdata   (data_out)
  );

  // Freshness check: counter must move forward by 1..WINDOW, wrapping.
  always_comb begin
    diff   = mod_diff(rx_cnt, last_count);
    accept = (diff != 8'd0) && (diff <= WIN8);
  end

  // Next-state, buffer control and next values of the registered strobes.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    drain_idx_next = drain_idx;
    cnt_capture    = 1'b0;
    buf_we         = 1'b0;
    buf_re         = 1'b0;
    buf_raddr      = {IDX_W{1'b0}};
    valid_next     = 1'b0;
    last_next      = 1'b0;
    err_next       = 1'b0;
    case (state)
      COLLECT: begin
        if (data_valid) begin
          if (idx == PLEN) begin
            cnt_capture = 1'b1;
            idx_next    = {IDX_W{1'b0}};
            state_next  = CHECK;
          end else begin
            buf_we   = 1'b1;
            idx_next = idx + IDX_W'(1);
          end
        end else begin
          idx_next = idx;
        end
      end
      CHECK: begin
        if (accept) begin
          // Prefetch byte 0 so it appears in the first DRAIN cycle.
          state_next     = DRAIN;
          drain_idx_next = {IDX_W{1'b0}};
          buf_re         = 1'b1;
          buf_raddr      = {IDX_W{1'b0}};
          valid_next     = 1'b1;
          last_next      = (LAST_IDX == {IDX_W{1'b0}});
        end else begin
          state_next = COLLECT;
          err_next   = 1'b1;
        end
      end
      DRAIN: begin
        // drain_idx is the byte currently on data_out.
        if (drain_idx == LAST_IDX) begin
          state_next     = COLLECT;
          drain_idx_next = {IDX_W{1'b0}};
        end else begin
          drain_idx_next = drain_idx + IDX_W'(1);
          buf_re         = 1'b1;
          buf_raddr      = drain_idx + IDX_W'(1);
          valid_next     = 1'b1;
          last_next      = ((drain_idx + IDX_W'(1)) == LAST_IDX);
        end
      end
      default: begin
        state_next = COLLECT;
        idx_next   = {IDX_W{1'b0}};
      end
    endcase
  end

  // FSM and frame index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= COLLECT;
      idx       <= {IDX_W{1'b0}};
      drain_idx <= {IDX_W{1'b0}};
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      drain_idx <= drain_idx_next;
    end
  end

  // Received counter byte and last accepted counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt     <= 8'h00;
      last_count <= 8'h00;
    end else begin
      rx_cnt     <= cnt_capture ? data_in : rx_cnt;
      last_count <= ((state == CHECK) && accept) ? rx_cnt : last_count;
    end
  end

  // Saturating rejected-frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= {ERR_CNT_W{1'b0}};
    end else if (err_next && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end else begin
      err_count <= err_count;
    end
  end

  // Registered status strobes; in_ready follows the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready       <= 1'b1;
      data_out_valid <= 1'b0;
      frame_last     <= 1'b0;
      replay_error   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      in_ready       <= (state_next == COLLECT);
      data_out_valid <= valid_next;
      frame_last     <= last_next;
      replay_error   <= err_next;
      overrun        <= data_valid && (state != COLLECT);
    end
  end

endmodule

// File: tb/tb_replay_protection_rx.sv
// Self-checking bench for replay_protection_rx: table of frames with expected
// accept/reject outcomes plus hand-written overrun and reset-mid-drain cases.
// Released payload bytes are checked through a scoreboard queue.
module tb_replay_protection_rx;

  localparam int L = 8;

  typedef struct {
    logic [7:0] base;
    logic [7:0] cnt;
    bit         acc;
    logic [7:0] exp_last;
    logic [7:0] exp_err;
  } row_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         due;
  } exp_byte_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       frame_last;
  logic       replay_error;
  logic       overrun;
  logic [7:0] err_count;
  logic [7:0] last_count;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int exp_err_cyc = -1;
  exp_byte_t sb[$];

  replay_protection_rx #(
    .PAYLOAD_LEN (L),
    .WINDOW      (16),
    .ERR_CNT_W   (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .in_ready       (in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .frame_last     (frame_last),
    .replay_error   (replay_error),
    .overrun        (overrun),
    .err_count      (err_count),
    .last_count     (last_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor on the falling edge: scoreboard for released bytes, pulse counts.
  always @(negedge clk) begin
    if (data_out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'd0, data_out_valid}, 32'd0);
      end else begin
        exp_byte_t e;
        e = sb.pop_front();
        chk("data_out", {24'd0, data_out}, {24'd0, e.data});
        chk("frame_last", {31'd0, frame_last}, {31'd0, e.last});
        chk("byte_timing", cyc, e.due);
      end
    end
    if (replay_error) begin
      err_seen++;
      chk("replay_err_timing", cyc, exp_err_cyc);
    end
    if (overrun) ovr_seen++;
  end

  // Send payload base..base+L-1 then the counter byte; called 1ns after a
  // rising edge. Pushes the first n_push bytes when acceptance is expected.
  task automatic send_frame(input logic [7:0] base, input logic [7:0] cnt,
                            input bit acc, input int n_push);
    int ctr_cyc;
    for (int i = 0; i <= L; i++) begin
      data_in    = (i < L) ? base + 8'(i) : cnt;
      data_valid = 1'b1;
      ctr_cyc    = cyc;
      @(posedge clk);
      #1;
    end
    data_valid = 1'b0;
    // Counter byte presented in cycle ctr_cyc; output two cycles later.
    if (acc) begin
      for (int i = 0; i < n_push; i++) begin
        exp_byte_t e;
        e.data = base + 8'(i);
        e.last = (i == L - 1);
        e.due  = ctr_cyc + 2 + i;
        sb.push_back(e);
      end
    end else begin
      exp_err_cyc = ctr_cyc + 2;
    end
  endtask

  row_t rows[23];
  logic [7:0] hold;

  initial begin
    int e0;
    int o0;
    rows[0] = '{8'h10, 8'h01, 1'b1, 8'h01, 8'd0};
    rows[1] = '{8'h10, 8'h01, 1'b0, 8'h01, 8'd1};
    rows[2] = '{8'h20, 8'h11, 1'b1, 8'h11, 8'd1};
    rows[3] = '{8'h30, 8'h22, 1'b0, 8'h11, 8'd2};
    rows[4] = '{8'h40, 8'h00, 1'b0, 8'h11, 8'd3};
    for (int k = 0; k < 14; k++) begin
      rows[5+k] = '{8'(8'h80 + k*8), 8'(8'h21 + k*16), 1'b1, 8'(8'h21 + k*16), 8'd3};
    end
    rows[19] = '{8'hA0, 8'hFA, 1'b1, 8'hFA, 8'd3};
    rows[20] = '{8'hB0, 8'h04, 1'b1, 8'h04, 8'd3};
    rows[21] = '{8'hC0, 8'h04, 1'b0, 8'h04, 8'd4};
    rows[22] = '{8'hD0, 8'h14, 1'b1, 8'h14, 8'd4};

    reset_n = 1'b1;
    data_in = 8'h00;
    data_valid = 1'b0;
    hold = 8'h00;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_flags", {28'd0, data_out_valid, frame_last, replay_error, overrun}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_last_count", {24'd0, last_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int r = 0; r < 23; r++) begin
      e0 = err_seen;
      send_frame(rows[r].base, rows[r].cnt, rows[r].acc, L);
      repeat (L + 3) @(posedge clk);
      #1;
      chk("drained", sb.size(), 32'd0);
      chk("err_pulses", err_seen - e0, rows[r].acc ? 32'd0 : 32'd1);
      chk("last_count", {24'd0, last_count}, {24'd0, rows[r].exp_last});
      chk("err_count", {24'd0, err_count}, {24'd0, rows[r].exp_err});
      if (rows[r].acc) hold = rows[r].base + 8'(L - 1);
      chk("data_out_hold", {24'd0, data_out}, {24'd0, hold});
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    end

    // Bytes offered while draining are dropped and flagged as overrun.
    o0 = ovr_seen;
    send_frame(8'h50, 8'h15, 1'b1, L);
    chk("in_ready_check", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
    data_in = 8'hEE;
    data_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    data_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("overrun_pulses", ovr_seen - o0, 32'd2);
    chk("ovr_drained", sb.size(), 32'd0);
    chk("ovr_last_count", {24'd0, last_count}, 32'h15);
    send_frame(8'h60, 8'h16, 1'b1, L);
    repeat (L + 3) @(posedge clk);
    #1;
    chk("post_ovr_drained", sb.size(), 32'd0);
    chk("post_ovr_last_count", {24'd0, last_count}, 32'h16);

    // Reset while byte 3 of an accepted frame is on the output.
    send_frame(8'h90, 8'h17, 1'b1, 3);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_flags", {28'd0, data_out_valid, frame_last, replay_error, overrun}, 32'd0);
    chk("mid_rst_data_out", {24'd0, data_out}, 32'd0);
    chk("mid_rst_counts", {16'd0, err_count, last_count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("mid_rst_partial", sb.size(), 32'd0);
    send_frame(8'h70, 8'h01, 1'b1, L);
    repeat (L + 3) @(posedge clk);
    #1;
    chk("after_rst_drained", sb.size(), 32'd0);
    chk("after_rst_last_count", {24'd0, last_count}, 32'h01);
    chk("after_rst_err_count", {24'd0, err_count}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
